// File: rtl/complete_arbiter_pkg.sv
// Shared CDB field widths, default arbiter sizing and the load-source index.
package complete_arbiter_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned PRW_DEF  = 6;
  localparam int unsigned ROBW_DEF = 4;
  localparam int unsigned PC_W     = 32;

  localparam int unsigned NSRC_DEF = 4;
  localparam int unsigned NCDB_DEF = 2;

  // The highest-numbered source is the load path from the MEM->Complete register.
  localparam int unsigned SRC_LOAD = NSRC_DEF - 1;

  // Width of one packed holding-FIFO entry {pc, rob, pd, data}.
  function automatic int unsigned entry_width(input int unsigned dw,
                                              input int unsigned prw,
                                              input int unsigned robw);
    return dw + prw + robw + PC_W;
  endfunction

endpackage

// File: rtl/complete_arbiter_result_fifo2.sv
// Two-entry holding FIFO for one result source: push/pop/count/flush.
module result_fifo2 #(
  parameter int unsigned W = 74
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && (r_cnt != 2'd2);
  assign w_do_pop  = i_pop  && (r_cnt != 2'd0);
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_cnt;

  // Storage, pointers and occupancy; flush empties the FIFO and beats any push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_do_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: per-source 2-entry FIFOs, round-robin grant of up to
// NCDB heads per cycle, registered CDB broadcast ports.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEF,
  parameter int unsigned NCDB = NCDB_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned PRW  = PRW_DEF,
  parameter int unsigned ROBW = ROBW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*DW-1:0]   src_data,
  input  logic [NSRC*PRW-1:0]  src_pd,
  input  logic [NSRC*ROBW-1:0] src_rob,
  input  logic [NSRC*32-1:0]   src_pc,
  output logic [NCDB-1:0]      cdb_valid,
  output logic [NCDB*DW-1:0]   cdb_data,
  output logic [NCDB*PRW-1:0]  cdb_pd,
  output logic [NCDB*ROBW-1:0] cdb_rob,
  output logic [NCDB*32-1:0]   cdb_pc
);

  localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CW = (NCDB > 1) ? $clog2(NCDB) : 1;
  localparam int unsigned EW = entry_width(DW, PRW, ROBW);

  logic [SW-1:0]   r_rr;
  logic [SW-1:0]   w_rr_nxt;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  logic [NSRC-1:0] w_empty;
  logic [1:0]      w_count [NSRC];
  logic [EW-1:0]   w_din   [NSRC];
  logic [EW-1:0]   w_head  [NSRC];
  logic [NCDB-1:0] w_gnt_vld;
  logic [SW-1:0]   w_gnt_idx [NCDB];

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign w_din[g]     = {src_pc[g*32 +: 32], src_rob[g*ROBW +: ROBW],
                           src_pd[g*PRW +: PRW], src_data[g*DW +: DW]};
    assign src_ready[g] = (w_count[g] != 2'd2);
    assign w_push[g]    = src_valid[g] & src_ready[g];
    assign w_empty[g]   = (w_count[g] == 2'd0);

    result_fifo2 #(
      .W (EW)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (w_din[g]),
      .o_data  (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Round-robin scan from r_rr: the first NCDB non-empty FIFOs win, grant k -> port k.
  // Index wraps by conditional subtract so NSRC need not be a power of two.
  always_comb begin
    logic [SW:0]   v_sum;
    logic [SW-1:0] v_idx;
    logic [CW:0]   v_n;
    w_pop     = '0;
    w_gnt_vld = '0;
    w_rr_nxt  = r_rr;
    v_sum     = '0;
    v_idx     = '0;
    v_n       = '0;
    for (int unsigned k = 0; k < NCDB; k++) begin
      w_gnt_idx[k] = '0;
    end
    for (int unsigned k = 0; k < NSRC; k++) begin
      v_sum = {1'b0, r_rr} + (SW+1)'(k);
      if (v_sum >= (SW+1)'(NSRC)) begin
        v_sum = v_sum - (SW+1)'(NSRC);
      end
      v_idx = v_sum[SW-1:0];
      if (!w_empty[v_idx] && (v_n < (CW+1)'(NCDB))) begin
        w_pop[v_idx]            = 1'b1;
        w_gnt_vld[v_n[CW-1:0]]  = 1'b1;
        w_gnt_idx[v_n[CW-1:0]]  = v_idx;
        v_n                     = v_n + (CW+1)'(1);
        w_rr_nxt                = (v_idx == SW'(NSRC-1)) ? '0 : v_idx + SW'(1);
      end
    end
  end

  // CDB output register and round-robin pointer; ungranted ports keep their payload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr      <= '0;
      cdb_valid <= '0;
      cdb_data  <= '0;
      cdb_pd    <= '0;
      cdb_rob   <= '0;
      cdb_pc    <= '0;
    end else if (flush) begin
      r_rr      <= '0;
      cdb_valid <= '0;
    end else begin
      r_rr <= w_rr_nxt;
      for (int unsigned k = 0; k < NCDB; k++) begin
        cdb_valid[k] <= w_gnt_vld[k];
        if (w_gnt_vld[k]) begin
          {cdb_pc[k*32 +: 32], cdb_rob[k*ROBW +: ROBW],
           cdb_pd[k*PRW +: PRW], cdb_data[k*DW +: DW]} <= w_head[w_gnt_idx[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed self-checking bench for complete_arbiter.
module tb_complete_arbiter;

  localparam int NSRC = 4;
  localparam int NCDB = 2;
  localparam int DW   = 32;
  localparam int PRW  = 6;
  localparam int ROBW = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 flush = 1'b0;
  logic [NSRC-1:0]      src_valid = '0;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*DW-1:0]   src_data = '0;
  logic [NSRC*PRW-1:0]  src_pd = '0;
  logic [NSRC*ROBW-1:0] src_rob = '0;
  logic [NSRC*32-1:0]   src_pc = '0;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*DW-1:0]   cdb_data;
  logic [NCDB*PRW-1:0]  cdb_pd;
  logic [NCDB*ROBW-1:0] cdb_rob;
  logic [NCDB*32-1:0]   cdb_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  complete_arbiter #(
    .NSRC (NSRC),
    .NCDB (NCDB),
    .DW   (DW),
    .PRW  (PRW),
    .ROBW (ROBW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_pd    (src_pd),
    .src_rob   (src_rob),
    .src_pc    (src_pc),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_pd    (cdb_pd),
    .cdb_rob   (cdb_rob),
    .cdb_pc    (cdb_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] d, input logic [PRW-1:0] pd,
                         input logic [ROBW-1:0] rob, input logic [31:0] pc);
    src_valid[i]            = 1'b1;
    src_data[i*DW +: DW]    = d;
    src_pd[i*PRW +: PRW]    = pd;
    src_rob[i*ROBW +: ROBW] = rob;
    src_pc[i*32 +: 32]      = pc;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", cdb_valid); end
    total++; if (cdb_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", cdb_data); end
    total++; if ({cdb_pd, cdb_rob, cdb_pc} !== '0) begin bad++; $display("FAIL rst_fields got=%h exp=0", {cdb_pd, cdb_rob, cdb_pc}); end
    rstn = 1'b1;
    #1;
    total++; if (src_ready !== 4'hF) begin bad++; $display("FAIL rst_ready got=%h exp=f", src_ready); end
  endtask

  task automatic test_single();
    set_src(0, 32'h1234, 6'd5, 4'd3, 32'h0000_1000);
    tick();
    idle();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_nobypass got=%b exp=00", cdb_valid); end
    tick();
    total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b exp=01", cdb_valid); end
    total++; if (cdb_data[0 +: DW] !== 32'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", cdb_data[0 +: DW]); end
    total++; if (cdb_pd[0 +: PRW] !== 6'd5) begin bad++; $display("FAIL single_pd got=%0d exp=5", cdb_pd[0 +: PRW]); end
    total++; if (cdb_rob[0 +: ROBW] !== 4'd3) begin bad++; $display("FAIL single_rob got=%0d exp=3", cdb_rob[0 +: ROBW]); end
    total++; if (cdb_pc[0 +: 32] !== 32'h0000_1000) begin bad++; $display("FAIL single_pc got=%h exp=1000", cdb_pc[0 +: 32]); end
    tick();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_after got=%b exp=00", cdb_valid); end
  endtask

  task automatic test_all_four();
    do_flush();
    for (int s = 0; s < NSRC; s++) set_src(s, 32'hA0 + s, PRW'(s), ROBW'(s), 32'h2000 + s);
    tick();
    idle();
    tick();
    total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL all4_v1 got=%b exp=11", cdb_valid); end
    total++; if (cdb_data !== {32'hA1, 32'hA0}) begin bad++; $display("FAIL all4_d1 got=%h exp=000000a1000000a0", cdb_data); end
    tick();
    total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL all4_v2 got=%b exp=11", cdb_valid); end
    total++; if (cdb_data !== {32'hA3, 32'hA2}) begin bad++; $display("FAIL all4_d2 got=%h exp=000000a3000000a2", cdb_data); end
    // Only rr_ptr=0 puts source 0 ahead of source 3.
    set_src(0, 32'hB0, 6'd0, 4'd0, 32'h0);
    set_src(3, 32'hB3, 6'd3, 4'd3, 32'h0);
    tick();
    idle();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL all4_gap got=%b exp=00", cdb_valid); end
    tick();
    total++; if (cdb_data !== {32'hB3, 32'hB0}) begin bad++; $display("FAIL all4_rr0 got=%h exp=000000b3000000b0", cdb_data); end
    tick();
  endtask

  task automatic test_fairness();
    int seq [NSRC];
    int got [NSRC];
    logic [NSRC-1:0] acc;
    int r0;
    int r1;
    do_flush();
    for (int s = 0; s < NSRC; s++) begin seq[s] = 0; got[s] = 0; end
    for (int c = 0; c < 9; c++) begin
      for (int s = 0; s < NSRC; s++) set_src(s, 32'hF000_0000 + s * 256 + seq[s], PRW'(s), ROBW'(s), 32'h0);
      acc = src_valid & src_ready;
      tick();
      for (int s = 0; s < NSRC; s++) if (acc[s]) seq[s]++;
      if (c >= 1) begin
        r0 = ((c - 1) % 2 == 0) ? 0 : 2;
        r1 = r0 + 1;
        total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL fair_valid c=%0d got=%b exp=11", c, cdb_valid); end
        total++; if (cdb_rob !== {4'(r1), 4'(r0)}) begin bad++; $display("FAIL fair_pair c=%0d got=%h exp=%0d%0d", c, cdb_rob, r1, r0); end
        for (int p = 0; p < NCDB; p++) begin
          int s;
          s = int'(cdb_rob[p*ROBW +: ROBW]);
          if (s < NSRC) begin
            total++; if (cdb_data[p*DW +: DW] !== 32'hF000_0000 + s * 256 + got[s]) begin bad++; $display("FAIL fair_order src=%0d got=%h exp=%h", s, cdb_data[p*DW +: DW], 32'hF000_0000 + s * 256 + got[s]); end
            got[s]++;
          end
        end
      end
    end
    idle();
    for (int s = 0; s < NSRC; s++) begin
      total++; if (got[s] !== 4) begin bad++; $display("FAIL fair_count src=%0d got=%0d exp=4", s, got[s]); end
    end
    do_flush();
  endtask

  task automatic test_backpressure();
    int seq3;
    int nb3;
    logic acc;
    do_flush();
    seq3 = 0;
    nb3 = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 6) begin
        for (int s = 0; s < NSRC - 1; s++) set_src(s, 32'h0000_0100 * s, PRW'(s), ROBW'(s), 32'h0);
        set_src(3, 32'hD000_0000 + seq3, 6'd3, 4'd3, 32'h0);
      end else begin
        idle();
      end
      acc = src_valid[3] & src_ready[3];
      tick();
      if (acc) seq3++;
      if (c == 0) begin total++; if (src_ready[3] !== 1'b1) begin bad++; $display("FAIL bp_ready_e0 got=%b exp=1", src_ready[3]); end end
      if (c == 1) begin total++; if (src_ready[3] !== 1'b0) begin bad++; $display("FAIL bp_ready_e1 got=%b exp=0", src_ready[3]); end end
      if (c == 2) begin total++; if (src_ready[3] !== 1'b1) begin bad++; $display("FAIL bp_ready_e2 got=%b exp=1", src_ready[3]); end end
      for (int p = 0; p < NCDB; p++) begin
        if (cdb_valid[p] && cdb_rob[p*ROBW +: ROBW] == 4'd3) begin
          total++; if (cdb_data[p*DW +: DW] !== 32'hD000_0000 + nb3) begin bad++; $display("FAIL bp_order got=%h exp=%h", cdb_data[p*DW +: DW], 32'hD000_0000 + nb3); end
          nb3++;
        end
      end
    end
    total++; if (seq3 !== 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", seq3); end
    total++; if (nb3 !== 4) begin bad++; $display("FAIL bp_broadcast got=%0d exp=4", nb3); end
  endtask

  task automatic test_flush();
    do_flush();
    for (int s = 0; s < NSRC; s++) set_src(s, 32'hEE00 + s, PRW'(s), ROBW'(s), 32'h0);
    tick();
    idle();
    set_src(2, 32'hEEFF, 6'd2, 4'd2, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", cdb_valid); end
    total++; if (src_ready !== 4'hF) begin bad++; $display("FAIL flush_ready got=%h exp=f", src_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_stale c=%0d got=%b exp=00", c, cdb_valid); end
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < NSRC; s++) set_src(s, 32'hC0 + s, PRW'(s), ROBW'(s), 32'h3000 + s);
    tick();
    idle();
    tick();
    total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL rmid_pre got=%b exp=11", cdb_valid); end
    #1 rstn = 1'b0;
    #1;
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rmid_valid got=%b exp=00", cdb_valid); end
    total++; if ({cdb_data, cdb_pd, cdb_rob, cdb_pc} !== '0) begin bad++; $display("FAIL rmid_fields got=%h exp=0", {cdb_data, cdb_pd, cdb_rob, cdb_pc}); end
    #1 rstn = 1'b1;
    set_src(2, 32'h77, 6'd9, 4'd7, 32'h4000);
    tick();
    idle();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rmid_lat got=%b exp=00", cdb_valid); end
    tick();
    total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL rmid_new_v got=%b exp=01", cdb_valid); end
    total++; if (cdb_data[0 +: DW] !== 32'h77) begin bad++; $display("FAIL rmid_new_d got=%h exp=77", cdb_data[0 +: DW]); end
    total++; if (cdb_rob[0 +: ROBW] !== 4'd7) begin bad++; $display("FAIL rmid_new_rob got=%0d exp=7", cdb_rob[0 +: ROBW]); end
    tick();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rmid_lost got=%b exp=00", cdb_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Completion-stage arbiter between the functional-unit result pipes and the common data bus (CDB).
- Consumes results from ALU pipes and from the MEM->Complete pipeline register (load results), each through a per-source 2-entry holding FIFO.
- Grants up to NCDB results per cycle onto registered CDB ports feeding the ROB, reservation stations and the physical register file.
- Drives per-source ready so FUs stall instead of dropping results.

Parameters:
- NSRC, 4, number of result sources; source NSRC-1 is the load path from the MEM->Complete register.
- NCDB, 2, number of CDB broadcast ports; 1 <= NCDB <= NSRC.
- DW, 32, result data width.
- PRW, 6, physical destination register index width.
- ROBW, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict).
- src_valid  in  NSRC  per-source result valid.
- src_ready  out  NSRC  per-source FIFO not full.
- src_data  in  NSRC*DW  result data; source i at [i*DW +: DW].
- src_pd  in  NSRC*PRW  physical destination; source i at [i*PRW +: PRW].
- src_rob  in  NSRC*ROBW  ROB tag; source i at [i*ROBW +: ROBW].
- src_pc  in  NSRC*32  instruction PC, for debug/trace.
- cdb_valid  out  NCDB  broadcast valid per CDB port.
- cdb_data  out  NCDB*DW  broadcast data.
- cdb_pd  out  NCDB*PRW  broadcast physical destination.
- cdb_rob  out  NCDB*ROBW  broadcast ROB tag.
- cdb_pc  out  NCDB*32  broadcast PC.

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset state: all FIFOs empty, count=0; rr_ptr=0; all cdb_* outputs 0; src_ready all 1 once reset deasserts.
- Push:
  - src_valid[i] && src_ready[i] writes {data,pd,rob,pc} into FIFO i.
  - src_valid with src_ready low is ignored; the FU must hold its result.
- src_ready[i] = (count_i < 2), combinational from registered count only, with no pop look-ahead.
- Arbitration (combinational each cycle):
  - Scan sources rr_ptr, rr_ptr+1, ... modulo NSRC.
  - Grant the first NCDB non-empty FIFOs, one pop per FIFO per cycle.
  - Grant k goes to CDB port k, in scan order.
- Output:
  - Granted heads are registered onto cdb_* at the next posedge.
  - Ungranted CDB ports get cdb_valid=0; data is don't-care, held at the previous value.
  - Latency: accepted at edge t, earliest broadcast visible after edge t+1 (one cycle of FIFO, one of output register). There is no same-cycle bypass.
- Round robin: rr_ptr <- (last granted index + 1) mod NSRC; unchanged if nothing is granted.
- Simultaneous push and pop on the same FIFO: both take effect; count is unchanged; FIFO order is preserved.
- Full FIFO (count=2) with a pop: ready is still low that cycle, so no push; ready rises the next cycle.
- Flush:
  - Next edge: all FIFOs cleared, rr_ptr=0, cdb_valid=0.
  - Flush wins over a same-cycle push and grant; nothing accepted or granted that cycle appears on the CDB.
- Reset mid-operation: immediate asynchronous clear to reset state; in-flight entries are lost.
- Ordering: per-source FIFO order is guaranteed. No ordering is guaranteed across sources; the ROB tag resolves it.

Decomposition:
- Shared package/header:
  - CDB field widths DW, PRW, ROBW.
  - Default NSRC/NCDB.
  - Source index constant SRC_LOAD = NSRC-1.
- One natural sub-module, result_fifo2: 2-entry FIFO with push/pop/count/flush, instantiated NSRC times via generate.
- The arbiter and output register stay in the top module.

Test Plan:
- Single result: src_valid[0] with data=32'h1234, pd=5, rob=3 for one cycle -> two edges later, cdb_valid=2'b01, cdb_data[0]=32'h1234, cdb_pd=5, cdb_rob=3; the following cycle cdb_valid=0.
- All four sources valid in one cycle with data 0xA0..0xA3, rr_ptr=0:
  - Cycle+2: ports carry 0xA0 and 0xA1.
  - Cycle+3: ports carry 0xA2 and 0xA3.
  - rr_ptr ends at 0.
- Backpressure: hold src_valid[3] high for 6 cycles while the other sources are continuously busy:
  - src_ready[3] drops after 2 unserviced pushes.
  - No entry is lost or duplicated; broadcast load data order matches push order.
- Fairness: all sources continuously valid for 8 cycles -> grant pairs are (0,1),(2,3),(0,1),... and each source gets exactly 4 broadcasts.
- Flush: fill FIFOs 0..3 with one entry each, assert flush for one cycle -> next cycle cdb_valid=0, src_ready=4'hF, and no stale entry is ever broadcast.
- Reset mid-operation: deassert rstn between edges while FIFOs are non-empty -> all cdb_* outputs are immediately 0; after release, the first new push broadcasts with correct latency.
